// File: rtl/paddle_ctrl.sv
// Paddle centre-row generator for one side of the Pong field.
// Tracks the ball in auto mode or follows debounced buttons in manual mode, moving once per divided tick.
module paddle_ctrl #(
  parameter int unsigned TICK_BITS   = 17,
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned PAD_HALF    = 20,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned INIT_Y      = 240,
  parameter int unsigned AI_DEADBAND = 4,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_mode,
  input  logic [9:0] ball_y_pos,
  output logic [9:0] paddle_pos,
  output logic       move_tick,
  output logic       paddle_moving
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned EXT_W  = 11;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HOLD_W = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;

  localparam logic [EXT_W-1:0]  POS_LO   = EXT_W'(PAD_HALF);
  localparam logic [EXT_W-1:0]  POS_HI   = EXT_W'(Y_MAX - PAD_HALF);
  localparam logic [EXT_W-1:0]  DEADBAND = EXT_W'(AI_DEADBAND);
  localparam logic [EXT_W-1:0]  STEP_1   = EXT_W'(1);
  localparam logic [EXT_W-1:0]  STEP_2   = EXT_W'(2);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(ACCEL_TICKS);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  // Index 0 = up, 1 = down.
  logic [1:0]            btn_raw;
  logic [1:0][1:0]       btn_sync;
  logic [1:0]            deb_lvl;
  logic [1:0][DEB_W-1:0] deb_cnt;
  logic [1:0]            auto_sync;
  logic [TICK_BITS-1:0]  tick_cnt;
  logic                  tick_c;

  state_t            state, state_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt, hold_eff;
  logic              last_up, last_up_nxt;
  logic              moving_nxt;
  logic [EXT_W-1:0]  pos_ext, ball_ext, step, target, clamped;

  assign btn_raw = {btn_down, btn_up};
  assign tick_c  = &tick_cnt;

  // Synchronizers, debouncers and the free-running move-tick divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync  <= '0;
      auto_sync <= '0;
      deb_lvl   <= '0;
      deb_cnt   <= '0;
      tick_cnt  <= '0;
    end else begin
      auto_sync <= {auto_sync[0], auto_mode};
      tick_cnt  <= tick_cnt + TICK_BITS'(1);
      for (int i = 0; i < 2; i++) begin
        btn_sync[i] <= {btn_sync[i][0], btn_raw[i]};
        if (btn_sync[i][1] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_lvl[i] <= btn_sync[i][1];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Mode, position and hold-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= MANUAL;
      paddle_pos    <= POS_W'(INIT_Y);
      hold          <= '0;
      last_up       <= 1'b0;
      move_tick     <= 1'b0;
      paddle_moving <= 1'b0;
    end else begin
      state         <= state_nxt;
      paddle_pos    <= pos_nxt;
      hold          <= hold_nxt;
      last_up       <= last_up_nxt;
      move_tick     <= tick_c;
      paddle_moving <= moving_nxt;
    end
  end

  // Next mode and position; everything only changes on a tick.
  always_comb begin
    state_nxt   = state;
    pos_nxt     = paddle_pos;
    hold_nxt    = hold;
    last_up_nxt = last_up;
    moving_nxt  = paddle_moving;
    hold_eff    = hold;
    step        = STEP_1;
    pos_ext     = EXT_W'(paddle_pos);
    ball_ext    = EXT_W'(ball_y_pos);
    target      = pos_ext;
    clamped     = pos_ext;

    if (tick_c) begin
      state_nxt = auto_sync[1] ? AUTO : MANUAL;
      if (state_nxt != state) hold_eff = '0;

      if (state_nxt == AUTO) begin
        if (ball_ext > pos_ext + DEADBAND) begin
          target = pos_ext + STEP_1;
        end else if (ball_ext + DEADBAND < pos_ext) begin
          target = pos_ext - STEP_1;
        end
        hold_nxt = hold_eff;
      end else if (deb_lvl[0] ^ deb_lvl[1]) begin
        if (deb_lvl[0] != last_up) hold_eff = '0;
        step = (hold_eff < HOLD_SAT) ? STEP_1 : STEP_2;
        if (deb_lvl[0]) begin
          target = (pos_ext < step) ? '0 : pos_ext - step;
        end else begin
          target = pos_ext + step;
        end
        hold_nxt    = (hold_eff < HOLD_SAT) ? hold_eff + HOLD_W'(1) : hold_eff;
        last_up_nxt = deb_lvl[0];
      end else begin
        hold_nxt = '0;
      end

      if (target < POS_LO) begin
        clamped = POS_LO;
      end else if (target > POS_HI) begin
        clamped = POS_HI;
      end else begin
        clamped = target;
      end

      pos_nxt    = POS_W'(clamped);
      moving_nxt = (pos_nxt != paddle_pos);
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus random stimulus against a rule-level reference model.
module tb_paddle_ctrl;

  localparam int TB_TICK_BITS = 2;
  localparam int TB_DEB       = 3;
  localparam int TB_ACCEL     = 2;
  localparam int TICK_P       = 1 << TB_TICK_BITS;
  localparam int LO           = 20;
  localparam int HI           = 459;
  localparam int DB           = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, auto_mode;
  logic [9:0] ball_y_pos;
  logic [9:0] paddle_pos;
  logic       move_tick;
  logic       paddle_moving;

  int checks = 0;
  int errors = 0;

  paddle_ctrl #(
    .TICK_BITS(TB_TICK_BITS),
    .DEB_CYCLES(TB_DEB),
    .ACCEL_TICKS(TB_ACCEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .auto_mode(auto_mode),
    .ball_y_pos(ball_y_pos),
    .paddle_pos(paddle_pos),
    .move_tick(move_tick),
    .paddle_moving(paddle_moving)
  );

  always #5 clk = ~clk;

  // Reference model state: per-edge view of the behavioural rules.
  int m_pos, m_moving, m_tick, m_mode, m_hold, m_prevup, m_cyc;
  int s1[3], s2[3];
  int lvl[2], run[2];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int old, tgt, st, up_l, dn_l, raw[3];
    if (reset) begin
      m_pos = 240; m_moving = 0; m_tick = 0; m_mode = 0; m_hold = 0; m_prevup = 0; m_cyc = 0;
      for (int i = 0; i < 3; i++) begin s1[i] = 0; s2[i] = 0; end
      for (int i = 0; i < 2; i++) begin lvl[i] = 0; run[i] = 0; end
      return;
    end
    up_l = lvl[0];
    dn_l = lvl[1];
    if (m_cyc % TICK_P == TICK_P - 1) begin
      if (s2[2] != m_mode) m_hold = 0;
      m_mode = s2[2];
      old = m_pos;
      tgt = m_pos;
      if (m_mode == 1) begin
        if (int'(ball_y_pos) > m_pos + DB) tgt = m_pos + 1;
        else if (int'(ball_y_pos) + DB < m_pos) tgt = m_pos - 1;
      end else if (up_l != dn_l) begin
        if (m_hold > 0 && up_l != m_prevup) m_hold = 0;
        st = (m_hold < TB_ACCEL) ? 1 : 2;
        tgt = (up_l == 1) ? m_pos - st : m_pos + st;
        if (m_hold < TB_ACCEL) m_hold++;
        m_prevup = up_l;
      end else begin
        m_hold = 0;
      end
      if (tgt < LO) tgt = LO;
      if (tgt > HI) tgt = HI;
      m_pos = tgt;
      m_moving = (m_pos != old) ? 1 : 0;
      m_tick = 1;
    end else begin
      m_tick = 0;
    end
    m_cyc++;
    // A button level is accepted after DEB consecutive differing synchronized samples.
    for (int i = 0; i < 2; i++) begin
      if (s2[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == TB_DEB) begin lvl[i] = s2[i]; run[i] = 0; end
      end else begin
        run[i] = 0;
      end
    end
    raw[0] = int'(btn_up); raw[1] = int'(btn_down); raw[2] = int'(auto_mode);
    for (int i = 0; i < 3; i++) begin s2[i] = s1[i]; s1[i] = raw[i]; end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pos", 32'(paddle_pos), m_pos);
    chk("tick", 32'(move_tick), m_tick);
    chk("moving", 32'(paddle_moving), m_moving);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * TICK_P && !seen; i++) begin
      cyc();
      if (move_tick === 1'b1) seen = 1;
    end
    if (!seen) chk("tick_timeout", 32'(0), 1);
  endtask

  task automatic next_move();
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      wait_tick();
      if (paddle_moving === 1'b1) seen = 1;
    end
    if (!seen) chk("move_timeout", 32'(0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    int ntick, prev, exp_down[4], seg;
    bit hit;
    reset = 1'b1; btn_up = 0; btn_down = 0; auto_mode = 0; ball_y_pos = 10'd240;
    @(negedge clk);

    // Idle after reset.
    do_reset();
    chk("reset_pos", 32'(paddle_pos), 240);
    ntick = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (move_tick === 1'b1) ntick++;
    end
    chk("idle_ticks", 32'(ntick), 5);
    chk("idle_pos", 32'(paddle_pos), 240);
    chk("idle_moving", 32'(paddle_moving), 0);

    // Manual hold down with acceleration.
    do_reset();
    btn_down = 1;
    wait_tick();
    chk("down_first_tick", 32'(paddle_pos), 240);
    exp_down[0] = 241; exp_down[1] = 242; exp_down[2] = 244; exp_down[3] = 246;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      chk("down_hold_pos", 32'(paddle_pos), exp_down[i]);
      chk("down_hold_moving", 32'(paddle_moving), 1);
    end
    btn_down = 0;
    cycles(12);

    // Both buttons: no move; release up restarts at speed 1.
    do_reset();
    btn_up = 1; btn_down = 1;
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      chk("both_pos", 32'(paddle_pos), 240);
      chk("both_moving", 32'(paddle_moving), 0);
    end
    btn_up = 0;
    next_move();
    chk("release_first", 32'(paddle_pos), 241);
    wait_tick();
    chk("release_second", 32'(paddle_pos), 242);

    // Clamp at bottom, then reverse to the top.
    do_reset();
    btn_down = 1;
    prev = 240; hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      wait_tick();
      if (paddle_pos == 10'd459) hit = 1; else prev = int'(paddle_pos);
    end
    chk("bot_pre", 32'(prev), 458);
    chk("bot_reach", 32'(paddle_pos), 459);
    for (int i = 0; i < 2; i++) begin
      wait_tick();
      chk("bot_hold", 32'(paddle_pos), 459);
      chk("bot_moving", 32'(paddle_moving), 0);
    end
    btn_down = 0; btn_up = 1;
    prev = 459; hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      wait_tick();
      if (paddle_pos == 10'd20) hit = 1; else prev = int'(paddle_pos);
    end
    chk("top_pre", 32'(prev), 21);
    chk("top_reach", 32'(paddle_pos), 20);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      chk("top_hold", 32'(paddle_pos), 20);
      chk("top_moving", 32'(paddle_moving), 0);
    end
    btn_up = 0;
    cycles(12);

    // Glitch rejection.
    do_reset();
    cycles(8);
    btn_up = 1; cycles(2); btn_up = 0;
    cycles(20);
    chk("glitch_short", 32'(paddle_pos), 240);
    btn_up = 1; cycles(6); btn_up = 0;
    cycles(20);
    chk("glitch_long_moved", 32'(paddle_pos < 10'd240), 1);
    chk("glitch_long_range", 32'(paddle_pos >= 10'd238), 1);

    // Auto tracking and mid-run reset.
    do_reset();
    auto_mode = 1; ball_y_pos = 10'd250;
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      chk("auto_climb", 32'(paddle_pos), 241 + i);
    end
    for (int i = 0; i < 2; i++) begin
      wait_tick();
      chk("auto_hold", 32'(paddle_pos), 246);
      chk("auto_hold_moving", 32'(paddle_moving), 0);
    end
    ball_y_pos = 10'd100;
    wait_tick();
    chk("auto_down1", 32'(paddle_pos), 245);
    wait_tick();
    chk("auto_down2", 32'(paddle_pos), 244);
    cycles(1);
    reset = 1'b1;
    cyc();
    chk("midreset_pos", 32'(paddle_pos), 240);
    chk("midreset_moving", 32'(paddle_moving), 0);
    reset = 1'b0; auto_mode = 0;
    wait_tick();
    wait_tick();
    chk("midreset_manual", 32'(paddle_pos), 240);

    // Random stimulus against the model.
    do_reset();
    for (int k = 0; k < 150; k++) begin
      btn_up     = ($urandom_range(0, 2) == 0);
      btn_down   = ($urandom_range(0, 2) == 0);
      auto_mode  = ($urandom_range(0, 3) == 0);
      ball_y_pos = 10'($urandom_range(0, 1023));
      seg = $urandom_range(1, 40);
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      cyc();
      reset = 1'b0;
      cycles(seg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
